rom_arbiter: RTL and testbench
==============================

// Module: rom_arbiter
// PURPOSE
//  Shares one synchronous single-port ROM (registered q, 1-cycle read latency, read
//  when ce high) between two requesters: port 0 (CPU fetch path) and port 1 (secondary
//  reader, e.g. loader/patch engine). Fixed priority to port 0, with a starvation
//  guard for port 1. Sits between the requesters and the ROM instance.
// PARAMETERS
//  AW      14  ROM address width (ROM depth 2**AW bytes)
//  STARVE  3   consecutive port-0 grants allowed while port 1 waits (1..15)
// PORTS
//  clock    in   1   system clock, all logic on posedge
//  reset    in   1   asynchronous, active-low reset
//  req0     in   1   port 0 request, level, held until ack0
//  a0       in   AW  port 0 address, stable while req0 high
//  q0       out  8   port 0 read data, valid from ack0 until next port-0 ack
//  ack0     out  1   one-cycle pulse: q0 updated
//  req1     in   1   port 1 request, level, held until ack1
//  a1       in   AW  port 1 address, stable while req1 high
//  q1       out  8   port 1 read data, valid from ack1 until next port-1 ack
//  ack1     out  1   one-cycle pulse: q1 updated
//  rom_ce   out  1   ROM read enable (registered)
//  rom_a    out  AW  ROM address (registered)
//  rom_q    in   8   ROM data, valid the cycle after the edge sampling rom_ce=1
//  busy     out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0): state IDLE, rom_ce=0, rom_a=0, q0=q1=0, ack0=ack1=0, busy=0,
//   starve count=0, owner=0. Reset mid-transfer aborts it: no ack is issued.
//  FSM: IDLE -> ISSUE -> CAPTURE -> IDLE. All outputs registered.
//  IDLE: evaluate masked requests m0=req0&~ack0, m1=req1&~ack1 (a port is ignored on
//   the edge ending its ack cycle, so a requester dropping req on that edge is not
//   re-granted). Grant: m1&(~m0 | cnt==STARVE) -> port 1; else m0 -> port 0; else stay.
//   On grant: rom_a<=granted addr, rom_ce<=1, owner<=port, state<=ISSUE.
//  Starve count: port-0 grant while m1 high -> cnt+1 (saturate at STARVE);
//   any port-1 grant -> cnt<=0; port-0 grant with m1 low -> cnt<=0.
//  ISSUE: ROM samples ce/addr on this edge; rom_ce<=0, state<=CAPTURE.
//  CAPTURE: q[owner]<=rom_q, ack[owner]<=1 (one cycle), state<=IDLE.
//  Latency: req sampled at edge E0 -> ack high after E2 (3 edges). Single-port
//   back-to-back period 4 cycles; alternating ports 3 cycles (other port grantable
//   on the edge ending the ack cycle).
//  Requests arriving in ISSUE/CAPTURE wait; addresses sampled only at grant, so
//   changing a0/a1 after grant does not affect the access in flight.
//  Simultaneous req0/req1 in IDLE: port 0 wins unless cnt==STARVE.
//  ack0 and ack1 never high in the same cycle; rom_ce high exactly one cycle per grant.
//  qN holds last value when not acked; rom_a holds last granted address.
//  Requester dropping req before ack: access still completes and acks (harmless).
// TESTING
//  1 Reset: reset=0 with req0=1 -> all outputs 0, no rom_ce; release -> grant next edge.
//  2 Port 0 alone: ROM[0x0000]=0xF3, req0=1 a0=0 -> rom_ce 1 cycle, ack0 after 3
//    edges, q0=0xF3; req0 dropped on ack -> no second rom_ce.
//  3 Simultaneous: req0/req1 high, a0=0x0001 (0xAF), a1=0x3FFF (0x3C) -> ack0 first
//    q0=0xAF, then ack1 q1=0x3C, 3 cycles apart.
//  4 Starvation: req0 re-asserted continuously, req1 held -> exactly STARVE=3 port-0
//    acks then ack1; counter reset, pattern repeats.
//  5 Reset mid-op: assert reset during CAPTURE -> no ack, q0 unchanged at 0, FSM IDLE.
//  6 Address change after grant: a0 0x0010->0x0020 during ISSUE -> q0=ROM[0x0010].

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a synchronous single-port ROM with a registered q.
// Port 0 has fixed priority. A starvation counter lets port 1 in after STARVE port-0 grants.
module rom_arbiter #(
  parameter int AW     = 14,
  parameter int STARVE = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] a0,
  output logic [7:0]    q0,
  output logic          ack0,
  input  logic          req1,
  input  logic [AW-1:0] a1,
  output logic [7:0]    q1,
  output logic          ack1,
  output logic          rom_ce,
  output logic [AW-1:0] rom_a,
  input  logic [7:0]    rom_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_L = 4'(STARVE);

  state_t        state_r, state_s;
  logic          owner_r, owner_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          rom_ce_r, rom_ce_s;
  logic [AW-1:0] rom_a_r, rom_a_s;
  logic [7:0]    q0_r, q0_s;
  logic [7:0]    q1_r, q1_s;
  logic          ack0_r, ack0_s;
  logic          ack1_r, ack1_s;
  logic          busy_r, busy_s;
  logic          m0_s, m1_s;

  // A port still in its ack cycle is masked, so a requester releasing req on that edge is not re-granted.
  always_comb begin
    m0_s = req0 & ~ack0_r;
    m1_s = req1 & ~ack1_r;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    owner_s  = owner_r;
    cnt_s    = cnt_r;
    rom_ce_s = 1'b0;
    rom_a_s  = rom_a_r;
    q0_s     = q0_r;
    q1_s     = q1_r;
    ack0_s   = 1'b0;
    ack1_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (m1_s && (!m0_s || (cnt_r == STARVE_L))) begin
          rom_a_s  = a1;
          rom_ce_s = 1'b1;
          owner_s  = 1'b1;
          cnt_s    = 4'd0;
          state_s  = ISSUE;
        end else if (m0_s) begin
          rom_a_s  = a0;
          rom_ce_s = 1'b1;
          owner_s  = 1'b0;
          state_s  = ISSUE;
          if (m1_s) begin
            cnt_s = (cnt_r == STARVE_L) ? cnt_r : (cnt_r + 4'd1);
          end else begin
            cnt_s = 4'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        rom_ce_s = 1'b0;
        state_s  = CAPTURE;
      end
      CAPTURE: begin
        if (owner_r) begin
          q1_s   = rom_q;
          ack1_s = 1'b1;
        end else begin
          q0_s   = rom_q;
          ack0_s = 1'b1;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, owner and starvation count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_r  <= 1'b0;
      cnt_r    <= 4'd0;
      rom_ce_r <= 1'b0;
      rom_a_r  <= '0;
      q0_r     <= 8'd0;
      q1_r     <= 8'd0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      owner_r  <= owner_s;
      cnt_r    <= cnt_s;
      rom_ce_r <= rom_ce_s;
      rom_a_r  <= rom_a_s;
      q0_r     <= q0_s;
      q1_r     <= q1_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      busy_r   <= busy_s;
    end
  end

  assign rom_ce = rom_ce_r;
  assign rom_a  = rom_a_r;
  assign q0     = q0_r;
  assign q1     = q1_r;
  assign ack0   = ack0_r;
  assign ack1   = ack1_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: the stimulus queues the expected {port, data} in grant order,
// and a negedge monitor pops and compares the queue on every ack.
module tb_rom_arbiter;
  localparam int AW = 14;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [7:0]    q0, q1, rom_q = 8'd0;
  logic          ack0, ack1, rom_ce, busy;
  logic [AW-1:0] rom_a;

  logic [7:0] mem [0:(1<<AW)-1];
  exp_t       sb[$];
  int         ack_cyc[$];
  int         total = 0, bad = 0;
  int         cyc = 0, ce_cnt = 0;
  logic       prev_ce = 1'b0;
  int         c0, at, nacks;

  rom_arbiter #(.AW(AW), .STARVE(3)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .q0(q0), .ack0(ack0),
    .req1(req1), .a1(a1), .q1(q1), .ack1(ack1),
    .rom_ce(rom_ce), .rom_a(rom_a), .rom_q(rom_q), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ROM model: registered q, one-cycle latency
  always @(posedge clock) if (rom_ce) rom_q <= mem[rom_a];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input int port, input int limit, output int when);
    when = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) begin
      total++;
      bad++;
      $display("FAIL ack%0d_timeout: no ack within %0d cycles", port, limit);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and polices rom_ce and ack exclusivity
  always @(negedge clock) begin : mon
    exp_t e;
    if (ack0 && ack1) begin
      total++;
      bad++;
      $display("FAIL ack_exclusive: got ack0=1 ack1=1 expected at most one");
    end
    if (ack0 || ack1) begin
      ack_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
      end else begin
        e = sb.pop_front();
        check("ack_port", {31'd0, ack1}, {31'd0, e.port});
        check("ack_data", ack1 ? {24'd0, q1} : {24'd0, q0}, {24'd0, e.data});
      end
    end
    if (rom_ce) begin
      ce_cnt++;
      check("ce_one_cycle", {31'd0, prev_ce}, 32'd0);
    end
    prev_ce = rom_ce;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'(i >> 6) ^ 8'h5A;
    mem[14'h0000] = 8'hF3;
    mem[14'h0001] = 8'hAF;
    mem[14'h3FFF] = 8'h3C;
    mem[14'h0010] = 8'h42;
    mem[14'h0020] = 8'h99;
    mem[14'h0100] = 8'h11;
    mem[14'h0200] = 8'h22;

    // 1/2: reset with req0 pending, then a lone port-0 access
    req0 = 1'b1;
    a0   = 14'h0000;
    repeat (3) @(posedge clock);
    #1;
    check("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("rst_rom_a", {18'd0, rom_a}, 32'd0);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_q0", {24'd0, q0}, 32'd0);
    check("rst_q1", {24'd0, q1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    sb.push_back(exp_t'{port: 1'b0, data: 8'hF3});
    @(negedge clock);
    c0    = cyc;
    reset = 1'b1;
    @(negedge clock);
    check("grant_rom_ce", {31'd0, rom_ce}, 32'd1);
    check("grant_rom_a", {18'd0, rom_a}, 32'h0000);
    check("grant_busy", {31'd0, busy}, 32'd1);
    wait_ack(0, 10, at);
    check("latency_edges", at - c0, 32'd3);
    @(posedge clock);
    #1 req0 = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("single_ce_count", ce_cnt, 32'd1);
    check("q0_hold", {24'd0, q0}, 32'hF3);

    // 3: simultaneous requests, port 0 first then port 1 three cycles later
    ack_cyc.delete();
    c0 = ce_cnt;
    sb.push_back(exp_t'{port: 1'b0, data: 8'hAF});
    sb.push_back(exp_t'{port: 1'b1, data: 8'h3C});
    fork
      begin
        int w0;
        a0   = 14'h0001;
        req0 = 1'b1;
        wait_ack(0, 20, w0);
        @(posedge clock);
        #1 req0 = 1'b0;
      end
      begin
        int w1;
        a1   = 14'h3FFF;
        req1 = 1'b1;
        wait_ack(1, 20, w1);
        @(posedge clock);
        #1 req1 = 1'b0;
      end
    join
    repeat (4) @(posedge clock);
    #1;
    check("sim_ack_count", ack_cyc.size(), 32'd2);
    if (ack_cyc.size() == 2) check("sim_ack_spacing", ack_cyc[1] - ack_cyc[0], 32'd3);
    check("sim_q0", {24'd0, q0}, 32'hAF);
    check("sim_q1", {24'd0, q1}, 32'h3C);
    check("sim_ce_count", ce_cnt - c0, 32'd2);

    // 4: req1 present at each port-0 grant edge but not at the ack edges -> three port-0 grants, then port 1
    c0 = ce_cnt;
    a0 = 14'h0100;
    a1 = 14'h0200;
    for (int k = 0; k < 3; k++) sb.push_back(exp_t'{port: 1'b0, data: 8'h11});
    sb.push_back(exp_t'{port: 1'b1, data: 8'h22});
    sb.push_back(exp_t'{port: 1'b0, data: 8'h11});
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, 20, at);
      req1 = 1'b0;
      @(posedge clock);
      #1 req1 = 1'b1;
    end
    wait_ack(1, 20, at);
    req1 = 1'b0;
    wait_ack(0, 20, at);
    req0 = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("starve_ce_count", ce_cnt - c0, 32'd5);
    check("starve_sb_empty", sb.size(), 32'd0);
    check("starve_q1", {24'd0, q1}, 32'h22);

    // 6: address change during ISSUE does not affect the access in flight
    sb.push_back(exp_t'{port: 1'b0, data: 8'h42});
    a0   = 14'h0010;
    req0 = 1'b1;
    @(posedge clock);
    #1 a0 = 14'h0020;
    wait_ack(0, 10, at);
    @(posedge clock);
    #1 req0 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("addr_chg_q0", {24'd0, q0}, 32'h42);
    check("addr_chg_rom_a", {18'd0, rom_a}, 32'h0010);

    // 5: reset asserted during CAPTURE aborts the access
    @(negedge clock) reset = 1'b0;
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1;
    nacks = ack_cyc.size();
    a0    = 14'h0005;
    req0  = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_ack0", {31'd0, ack0}, 32'd0);
    check("abort_q0", {24'd0, q0}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rom_ce", {31'd0, rom_ce}, 32'd0);
    req0 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check("abort_no_ack", ack_cyc.size() - nacks, 32'd0);
    check("abort_q0_after", {24'd0, q0}, 32'd0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
